// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver with frame snapshot, LZ blanking and ghost blanking
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 1,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [0:6]              seg7,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  localparam logic [0:6] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0] dps, lead;
  logic [3:0] digs [NUM_DIGITS];
  logic tick, lit, blank;
  logic [NUM_DIGITS-1:0] an_nx;
  logic [0:6] seg_nx;
  logic dp_nx;
  // lead[i]: every snapshot digit from the top down to i is zero
  always_comb begin
    lead = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digs[i] = snap[4*i +: 4];
      lead[i] = (digs[i] == 4'd0) && (i == NUM_DIGITS - 1 || lead[(i + 1) % NUM_DIGITS]);
    end
  end
  always_comb begin
    tick = en && pre == PLAST;
    lit = en && pre >= BLK;
    blank = lz_suppress && lead[idx] && idx != '0;
    an_nx = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    seg_nx = lit && !blank ? HEX[digs[idx]] : '1;
    dp_nx = !(lit && dps[idx]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
      snap <= '0;
      dps <= '0;
      an <= '1;
      seg7 <= '1;
      dp <= 1'b1;
    end else begin
      if (en) pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= idx == ILAST ? '0 : idx + 1'b1;
      if (!en || (tick && idx == ILAST)) begin
        snap <= value;
        dps <= dp_in;
      end
      an <= an_nx;
      seg7 <= seg_nx;
      dp <= dp_nx;
    end
  end
  assign digit_idx = idx;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench for a 4-digit and a 1-digit scan driver
module tb_seg7_scan_driver;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};
  logic clk = 0, rst_n = 1, en = 0, lz = 0, en1 = 0, dp_in1 = 0, lz1 = 0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, value1 = 4'hF;
  logic [3:0] an;
  logic [0:6] seg7, seg1;
  logic dp, dp1, an1, idx1;
  logic [1:0] idx;
  logic [11:0] q [$];
  logic [8:0] q1 [$];
  int checks = 0, errors = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
    .lz_suppress(lz), .seg7(seg7), .dp(dp), .an(an), .digit_idx(idx));
  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(2), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .value(value1), .dp_in(dp_in1),
    .lz_suppress(lz1), .seg7(seg1), .dp(dp1), .an(an1), .digit_idx(idx1));

  always #5 clk = ~clk;

  function automatic logic [11:0] lit(input int d, input logic [6:0] s, input logic p);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    return {a, s, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [11:0] e, input string tag);
    logic [11:0] x;
    q.push_back(e);
    @(posedge clk); #1;
    x = q.pop_front();
    checks++;
    assert ({an, seg7, dp} === x) else begin
      errors++;
      $error("FAIL %s: got an/seg/dp %h expected %h", tag, {an, seg7, dp}, x);
    end
  endtask

  task automatic slot(input int d, input logic [6:0] s, input logic p, input string tag);
    step(DARK, {tag, "_blank"});
    chk({tag, "_idx"}, 32'(idx), d);
    repeat (3) step(lit(d, s, p), tag);
  endtask

  // async reset with outputs checked before any clock edge
  task automatic reset_pulse(input string tag);
    rst_n = 0;
    #1;
    chk({tag, "_rst_out"}, 32'({an, seg7, dp}), 32'(DARK));
    chk({tag, "_rst_idx"}, 32'(idx), 0);
    #1 rst_n = 1;
  endtask

  initial begin
    #2;
    en = 1;
    reset_pulse("idle");
    for (int d = 0; d < 4; d++) slot(d, SEG[0], 1'b1, "idle");
    slot(0, SEG[0], 1'b1, "idle_wrap");

    en = 0; value = 16'hA5C3;
    reset_pulse("hex");
    step(DARK, "hex_off");
    en = 1;
    slot(0, SEG[3], 1'b1, "hex0");
    slot(1, SEG[12], 1'b1, "hex1");
    slot(2, SEG[5], 1'b1, "hex2");
    slot(3, SEG[10], 1'b1, "hex3");

    en = 0; value = 16'h1234;
    reset_pulse("tear");
    step(DARK, "tear_off");
    en = 1;
    slot(0, SEG[4], 1'b1, "tear0");
    slot(1, SEG[3], 1'b1, "tear1");
    step(DARK, "tear2_blank");
    value = 16'h5678;
    repeat (3) step(lit(2, SEG[2], 1'b1), "tear2");
    slot(3, SEG[1], 1'b1, "tear3");
    slot(0, SEG[8], 1'b1, "next0");
    slot(1, SEG[7], 1'b1, "next1");
    slot(2, SEG[6], 1'b1, "next2");
    slot(3, SEG[5], 1'b1, "next3");

    en = 0; lz = 1; value = 16'h0040; dp_in = 4'b1000;
    reset_pulse("lz");
    step(DARK, "lz_off");
    en = 1;
    slot(0, SEG[0], 1'b1, "lz0");
    slot(1, SEG[4], 1'b1, "lz1");
    slot(2, 7'h7F, 1'b1, "lz2");
    value = 16'h0000; dp_in = 4'b0000;
    slot(3, 7'h7F, 1'b0, "lz3");
    slot(0, SEG[0], 1'b1, "lzz0");
    slot(1, 7'h7F, 1'b1, "lzz1");
    slot(2, 7'h7F, 1'b1, "lzz2");
    slot(3, 7'h7F, 1'b1, "lzz3");
    lz = 0;

    en = 0; value = 16'h1234;
    reset_pulse("en");
    step(DARK, "en_off");
    en = 1;
    slot(0, SEG[4], 1'b1, "en0");
    step(DARK, "en1_blank");
    step(lit(1, SEG[3], 1'b1), "en1_pre1");
    en = 0;
    step(DARK, "en_frozen_a");
    step(DARK, "en_frozen_b");
    chk("en_frozen_idx", 32'(idx), 1);
    en = 1;
    step(lit(1, SEG[3], 1'b1), "en_resume_pre2");
    step(lit(1, SEG[3], 1'b1), "en_resume_pre3");
    step(DARK, "en2_blank");
    step(lit(2, SEG[2], 1'b1), "en2");
    reset_pulse("midrst");
    slot(0, SEG[0], 1'b1, "midrst0");

    reset_pulse("one");
    @(posedge clk); #1;
    chk("one_off", 32'({an1, seg1, dp1}), 32'({1'b1, 7'h7F, 1'b1}));
    en1 = 1;
    for (int i = 0; i < 6; i++) begin
      logic [8:0] x;
      q1.push_back({1'b0, SEG[15], 1'b1});
      @(posedge clk); #1;
      x = q1.pop_front();
      checks++;
      assert ({an1, seg1, dp1} === x) else begin
        errors++;
        $error("FAIL one_lit: got %h expected %h", {an1, seg1, dp1}, x);
      end
    end
    chk("one_idx", 32'(idx1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
